// File: rtl/display_pkg.sv
// Shared types and constants for the display sequencer: FSM states, the
// "no write" position code and the largest value the 8-digit display can show.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WRITE,
    DONE
  } state_t;

  localparam logic [3:0]  NO_POS            = 4'hF;
  localparam int unsigned MAX_DISPLAY_VALUE = 99_999_999;
  localparam int          DIGITS            = 8;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble correction step: adds 3 to every BCD nibble that is 5 or more,
// so that the following left shift carries correctly into the next decade.
module bcd_adjust #(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [4*DIGITS-1:0] bcd_out
);

  for (genvar i = 0; i < DIGITS; i++) begin : g_nibble
    assign bcd_out[4*i +: 4] = (bcd_in[4*i +: 4] >= 4'd5) ? bcd_in[4*i +: 4] + 4'd3
                                                           : bcd_in[4*i +: 4];
  end

endmodule

// File: rtl/display_seq.sv
// Converts a binary value to BCD with a serial double-dabble, then writes the
// digits to display positions 0..DIGITS-1, least significant digit first.
module display_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 27,
  parameter int DIGITS = display_pkg::DIGITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       data_out,
  output logic [3:0]       pos_out
);

  localparam int SR_W   = 4*DIGITS + WIDTH;
  localparam int ITER_W = $clog2(WIDTH);
  localparam int IDX_W  = $clog2(DIGITS);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_DISPLAY_VALUE[WIDTH-1:0];

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d, sr_shift;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [3:0]          data_q, data_d;
  logic [3:0]          pos_q, pos_d;
  logic [4*DIGITS-1:0] bcd_adj;

  bcd_adjust #(.DIGITS(DIGITS)) u_bcd_adjust (
    .bcd_in  (sr_q[SR_W-1:WIDTH]),
    .bcd_out (bcd_adj)
  );

  // Upper bits hold the BCD digits, lower WIDTH bits the binary still to shift in.
  assign sr_shift = {bcd_adj, sr_q[WIDTH-1:0]} << 1;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    iter_d     = iter_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = 1'b0;
    data_d     = 4'd0;
    pos_d      = NO_POS;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (value > MAX_VAL) begin
            state_d    = DONE;
            done_d     = 1'b1;
            overflow_d = 1'b1;
          end else begin
            state_d = CONVERT;
            sr_d    = {{(4*DIGITS){1'b0}}, value};
            iter_d  = '0;
          end
        end
      end
      CONVERT: begin
        sr_d = sr_shift;
        if (iter_q == ITER_W'(WIDTH-1)) begin
          state_d = WRITE;
          idx_d   = '0;
          pos_d   = 4'd0;
          data_d  = sr_shift[WIDTH +: 4];
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      WRITE: begin
        if (idx_q == IDX_W'(DIGITS-1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
          pos_d  = 4'(idx_d);
          data_d = sr_q[WIDTH + 4*int'(idx_d) +: 4];
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      iter_q     <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= 4'd0;
      pos_q      <= NO_POS;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      iter_q     <= iter_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      pos_q      <= pos_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign data_out = data_q;
  assign pos_out  = pos_q;

endmodule

// File: tb/tb_display_seq.sv
// Self-checking bench for display_seq: a scoreboard of expected writes and done
// pulses, each tagged with the cycle it must appear in relative to the accept edge.
module tb_display_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [26:0] value;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  data_out;
  logic [3:0]  pos_out;

  typedef struct {
    bit isDone;
    bit ovf;
    int pos;
    int data;
    int cycle;
  } expect_t;

  expect_t sb[$];
  int      cyc         = 0;
  int      testsRun    = 0;
  int      testsFailed = 0;

  display_seq #(.WIDTH(27), .DIGITS(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .data_out (data_out),
    .pos_out  (pos_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Outputs seen at a negedge were launched by edge cyc and are sampled by edge cyc+1.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (pos_out != 4'hF || done) begin
        if (sb.size() == 0) begin
          checkOutput("pending_expectations", 32'(sb.size()), 1);
        end else begin
          expect_t e;
          e = sb.pop_front();
          if (e.isDone) begin
            checkOutput("done", done, 1);
            checkOutput("overflow", overflow, e.ovf);
            checkOutput("done_pos", pos_out, 4'hF);
            checkOutput("done_cycle", cyc + 1, e.cycle);
          end else begin
            checkOutput("write_pos", pos_out, e.pos);
            checkOutput("write_data", data_out, e.data);
            checkOutput("write_cycle", cyc + 1, e.cycle);
          end
        end
      end
      if (pos_out < 4'd8) checkOutput("data_range", data_out < 4'd10, 1);
    end
  end

  task automatic applyStimulus(input logic [26:0] v);
    int t;
    int pw;
    expect_t e;
    @(negedge clock);
    start = 1'b1;
    value = v;
    @(posedge clock);
    #1;
    t = cyc;
    if (v > 27'd99_999_999) begin
      e = '{isDone: 1'b1, ovf: 1'b1, pos: 15, data: 0, cycle: t + 1};
      sb.push_back(e);
    end else begin
      pw = 1;
      for (int i = 0; i < 8; i++) begin
        e = '{isDone: 1'b0, ovf: 1'b0, pos: i, data: (int'(v) / pw) % 10, cycle: t + 28 + i};
        sb.push_back(e);
        pw = pw * 10;
      end
      e = '{isDone: 1'b1, ovf: 1'b0, pos: 15, data: 0, cycle: t + 36};
      sb.push_back(e);
    end
    checkOutput("busy_after_start", busy, 1);
    @(negedge clock);
    start = 1'b0;
    value = 27'($urandom);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput("drained", (!busy && sb.size() == 0), 1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_overflow", overflow, 0);
    checkOutput("reset_data", data_out, 0);
    checkOutput("reset_pos", pos_out, 4'hF);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    applyStimulus(27'd12_345_678); waitIdle(60);
    applyStimulus(27'd0);          waitIdle(60);
    applyStimulus(27'd99_999_999); waitIdle(60);
    applyStimulus(27'd100_000_000); waitIdle(10);
    applyStimulus(27'h7FF_FFFF);   waitIdle(10);
    applyStimulus(27'd90_817_263); waitIdle(60);

    // A start arriving mid-conversion must be dropped, not queued.
    applyStimulus(27'd42);
    repeat (9) @(negedge clock);
    start = 1'b1;
    value = 27'd5;
    @(posedge clock);
    #1;
    checkOutput("busy_ignored_start", busy, 1);
    @(negedge clock);
    start = 1'b0;
    waitIdle(60);

    // Abort with reset while position 3 is being written.
    applyStimulus(27'd87_654_321);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clock);
      if (pos_out == 4'd3) found = 1'b1;
    end
    checkOutput("reach_pos3", found, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_pos", pos_out, 4'hF);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    applyStimulus(27'd7);
    waitIdle(60);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/display_seq.md
Name: display_seq

Overview:
- Sequencer that drives the 8-digit display controller's write port (4-bit digit, 4-bit position).
- Accepts a binary value on a start pulse and converts it to 8 BCD digits with a serial double-dabble.
- Then writes the digits to positions 0..7, one per cycle, least significant digit at position 0.
- Sits between application logic (counters, ALU results) and the display controller.

Parameters:
- WIDTH, 27, binary input width; 27 bits covers 99_999_999.
- DIGITS, 8, number of BCD digits and display positions; fixed at 8 for the current board.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- value  input  WIDTH  binary value; captured on the accepted start edge.
- busy  output  1  high in CONVERT, WRITE and DONE.
- done  output  1  one-cycle pulse at the end of every accepted request.
- overflow  output  1  one-cycle pulse together with done when value > 99_999_999.
- data_out  output  4  digit to the display controller; always 0..9.
- pos_out  output  4  display position 0..7; 4'hF when no write is intended.

Behaviour:
- The display controller writes whenever pos < 8 and data < 10. The sequencer therefore suppresses writes by holding pos_out = 4'hF.
- Reset (reset low, asynchronous): state IDLE, busy=0, done=0, overflow=0, data_out=0, pos_out=4'hF, shift register cleared, counters cleared.
- All outputs are registered.
- FSM states: IDLE, CONVERT, WRITE, DONE.
- IDLE: if start=1 at edge t, capture value.
  - If value > 99_999_999: go to DONE; no CONVERT, no writes; overflow=1 in DONE.
  - Otherwise: load shift register {32'b0, value}, clear the iteration counter, go to CONVERT.
- CONVERT: one iteration per cycle, WIDTH cycles.
  - Each iteration adds 3 to every BCD nibble >= 5, then shifts left by 1, all combinationally in the same cycle.
  - After iteration WIDTH, go to WRITE with digit index 0.
- WRITE: at each cycle i = 0..DIGITS-1, pos_out=i and data_out=BCD nibble i. After i=DIGITS-1, go to DONE.
- DONE: one cycle; done=1, pos_out=4'hF, then IDLE.
- Timing for start accepted at edge t:
  - busy is high from t+1.
  - CONVERT occupies cycles t+1..t+27.
  - WRITE occupies t+28..t+35 (pos 0..7).
  - DONE occurs at t+36.
  - The next start is accepted at t+37.
  - An overflow request gives done at t+1.
- A start while busy is ignored, not queued. Value changes after capture have no effect.
- Outside WRITE, pos_out=4'hF and data_out=0.
- Reset asserted mid-CONVERT or mid-WRITE aborts the operation immediately.
  - Positions already written keep their values in the display controller.
  - No done pulse is produced.
- start and reset release in the same cycle: start is ignored until the first edge with reset high.

Decomposition:
- Shared package display_pkg: state enum (IDLE, CONVERT, WRITE, DONE), NO_POS = 4'hF, MAX_DISPLAY_VALUE = 99_999_999, DIGITS = 8.
- Sub-module bcd_adjust: combinational add-3-if-≥5 across DIGITS nibbles; instantiated once, feeding the shift.

Test Plan:
- value=12_345_678, start pulse → WRITE cycles show (pos,data) = (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1); done at t+36; overflow=0.
- value=0 → eight writes of data 0 at pos 0..7; done at t+36.
- value=99_999_999 → eight writes of 9; value=100_000_000 → done and overflow at t+1, pos_out stays 4'hF throughout.
- Second start with value=5 at t+10 during the first request (value=42) → only the 42 sequence appears (pos0=2, pos1=4, rest 0); exactly one done.
- reset low during WRITE at pos 3 → pos_out=4'hF and busy=0 asynchronously, no done. After release, a start with value=7 completes normally: pos0=7, others 0.
- Throughout all scenarios, whenever pos_out < 8, data_out < 10 is asserted; pos_out is 4'hF in every non-WRITE cycle.
